// File: rtl/iomem_pkg.sv
// Shared widths, decode field and FSM encoding for the picosoc iomem crossbar.
package iomem_pkg;

  localparam int IOMEM_AW = 32;
  localparam int IOMEM_DW = 32;
  localparam int DEC_MSB  = 31;
  localparam int DEC_LSB  = 24;
  localparam int DEC_W    = DEC_MSB - DEC_LSB + 1;

  localparam logic [IOMEM_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } xbar_state_e;

endpackage

// File: rtl/iomem_addr_decode.sv
// Combinational slot decode on the address top byte; the lowest index wins when bases overlap.
module iomem_addr_decode
  import iomem_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [8*NUM_SLAVES-1:0]   SLAVE_BASE = {8'h06, 8'h05, 8'h04, 8'h03}
) (
  input  logic [DEC_W-1:0]      tag_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  miss_o
);

  // Scan from the top so a lower matching index overrides a higher one.
  always_comb begin
    hit_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (tag_i == SLAVE_BASE[8*i +: 8]) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
      end
    end
  end

  assign miss_o = ~|hit_o;

endmodule

// File: rtl/iomem_xbar.sv
// iomem decoder/arbiter: one outstanding request, registered responses, decode and timeout errors.
module iomem_xbar
  import iomem_pkg::*;
#(
  parameter int                      NUM_SLAVES     = 4,
  parameter logic [8*NUM_SLAVES-1:0] SLAVE_BASE     = {8'h06, 8'h05, 8'h04, 8'h03},
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [IOMEM_DW-1:0]     ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic                           m_valid_i,
  output logic                           m_ready_o,
  input  logic [3:0]                     m_wstrb_i,
  input  logic [IOMEM_AW-1:0]            m_addr_i,
  input  logic [IOMEM_DW-1:0]            m_wdata_i,
  output logic [IOMEM_DW-1:0]            m_rdata_o,
  output logic [NUM_SLAVES-1:0]          s_valid_o,
  input  logic [NUM_SLAVES-1:0]          s_ready_i,
  input  logic [IOMEM_DW*NUM_SLAVES-1:0] s_rdata_i,
  output logic [3:0]                     s_wstrb_o,
  output logic [IOMEM_AW-1:0]            s_addr_o,
  output logic [IOMEM_DW-1:0]            s_wdata_o,
  input  logic                           err_clr_i,
  output logic                           err_flag_o,
  output logic [IOMEM_AW-1:0]            err_addr_o
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TC = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  xbar_state_e             state_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [NUM_SLAVES-1:0]   s_valid_q;
  logic                    m_ready_q;
  logic [IOMEM_DW-1:0]     m_rdata_q;
  logic [TW-1:0]           timer_q;
  logic [TW-1:0]           timer_d;
  logic                    skip_q;
  logic                    err_flag_q;
  logic [IOMEM_AW-1:0]     err_addr_q;

  logic [NUM_SLAVES-1:0]   dec_hit;
  logic                    dec_miss;
  logic                    sel_ready;
  logic [IOMEM_DW-1:0]     sel_rdata;

  iomem_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE)
  ) u_decode (
    .tag_i  (m_addr_i[DEC_MSB:DEC_LSB]),
    .hit_o  (dec_hit),
    .miss_o (dec_miss)
  );

  assign sel_ready = |(s_ready_i & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | s_rdata_i[IOMEM_DW*i +: IOMEM_DW];
    end
  end

  // Saturating so a disabled timeout never wraps.
  assign timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      s_valid_q  <= '0;
      m_ready_q  <= 1'b0;
      m_rdata_q  <= '0;
      timer_q    <= '0;
      skip_q     <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      m_ready_q <= 1'b0;
      if (err_clr_i) err_flag_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          skip_q  <= 1'b0;
          // picorv32 still shows valid in the cycle after a response; skip_q masks it.
          if (m_valid_i && !skip_q) begin
            if (dec_miss) begin
              state_q   <= ST_ERR;
              m_ready_q <= 1'b1;
              m_rdata_q <= ERR_RDATA;
            end else begin
              state_q   <= ST_WAIT;
              sel_q     <= dec_hit;
              s_valid_q <= dec_hit;
            end
          end
        end
        ST_WAIT: begin
          if (!m_valid_i) begin
            state_q   <= ST_IDLE;
            s_valid_q <= '0;
            timer_q   <= '0;
          end else if (sel_ready) begin
            state_q   <= ST_RESP;
            s_valid_q <= '0;
            m_ready_q <= 1'b1;
            m_rdata_q <= sel_rdata;
          end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TC)) begin
            state_q   <= ST_ERR;
            s_valid_q <= '0;
            m_ready_q <= 1'b1;
            m_rdata_q <= ERR_RDATA;
          end else begin
            timer_q <= timer_d;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          skip_q  <= 1'b1;
          timer_q <= '0;
        end
        ST_ERR: begin
          state_q    <= ST_IDLE;
          skip_q     <= 1'b1;
          timer_q    <= '0;
          err_flag_q <= 1'b1;
          err_addr_q <= m_addr_i;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_ready_o  = m_ready_q;
  assign m_rdata_o  = m_rdata_q;
  assign s_valid_o  = s_valid_q;
  assign s_wstrb_o  = m_wstrb_i;
  assign s_addr_o   = m_addr_i;
  assign s_wdata_o  = m_wdata_i;
  assign err_flag_o = err_flag_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_iomem_xbar.sv
// Scoreboard bench for iomem_xbar: slave models with programmable ready delay, response queue.
module tb_iomem_xbar;

  localparam int N = 4;
  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            m_valid = 1'b0;
  logic            m_ready;
  logic [3:0]      m_wstrb = '0;
  logic [31:0]     m_addr = '0;
  logic [31:0]     m_wdata = '0;
  logic [31:0]     m_rdata;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [32*N-1:0] s_rdata;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic            err_clr = 1'b0;
  logic            err_flag;
  logic [31:0]     err_addr;

  int          tests = 0;
  int          fails = 0;
  int          resp_cnt = 0;
  logic [31:0] exp_q[$];
  int          dly[N];
  int          cnt[N];
  logic [31:0] sdata[N];

  always #5 clk = ~clk;

  iomem_xbar #(
    .NUM_SLAVES     (N),
    .SLAVE_BASE     ({8'h06, 8'h05, 8'h04, 8'h03}),
    .TIMEOUT_CYCLES (16),
    .ERR_RDATA      (ERR_RD)
  ) dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .m_valid_i  (m_valid),
    .m_ready_o  (m_ready),
    .m_wstrb_i  (m_wstrb),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_rdata_o  (m_rdata),
    .s_valid_o  (s_valid),
    .s_ready_i  (s_ready),
    .s_rdata_i  (s_rdata),
    .s_wstrb_o  (s_wstrb),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .err_clr_i  (err_clr),
    .err_flag_o (err_flag),
    .err_addr_o (err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave i raises ready in its dly[i]-th valid cycle (0 = same cycle, -1 = never).
  always @(posedge clk)
    for (int i = 0; i < N; i++) cnt[i] <= s_valid[i] ? cnt[i] + 1 : 0;

  always_comb begin
    s_ready = '0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      s_ready[i]       = s_valid[i] && (cnt[i] == dly[i]);
      s_rdata[32*i +: 32] = sdata[i];
    end
  end

  always @(negedge clk) begin
    if (resetn && m_ready) begin
      resp_cnt++;
      if (exp_q.size() == 0) chk("unexpected_ready", 1, 0);
      else chk("m_rdata", m_rdata, exp_q.pop_front());
      chk("s_valid_in_resp", s_valid, 0);
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                      input logic [3:0] exp_sv, input int exp_lat, input int exp_svc,
                      input logic [31:0] exp_rd, input logic exp_flag, input logic is_err);
    int n = 0;
    int svc = 0;
    bit got = 0;
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = a; m_wstrb = ws; m_wdata = wd;
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      if (s_valid != 0) begin
        svc++;
        if (svc == 1) begin
          chk("s_valid", s_valid, exp_sv);
          chk("s_addr", s_addr, a);
          chk("s_wdata", s_wdata, wd);
          chk("s_wstrb", s_wstrb, ws);
        end
      end
      if (m_ready) got = 1;
    end
    chk("ack_seen", got, 1);
    if (!got) exp_q.delete();
    chk("latency", n - 1, exp_lat);
    chk("s_valid_cycles", svc, exp_svc);
    @(posedge clk); #1;
    m_valid = 1'b0; m_wstrb = '0;
    @(negedge clk);
    chk("single_ready", m_ready, 0);
    chk("err_flag", err_flag, exp_flag);
    if (is_err) chk("err_addr", err_addr, a);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", err_flag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    sdata[0] = 32'hA0A0_0000; sdata[1] = 32'h1234_5678;
    sdata[2] = 32'hCAFE_0002; sdata[3] = 32'h3333_3333;
    for (int i = 0; i < N; i++) dly[i] = 0;

    #12;
    chk("rst_m_ready", m_ready, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_addr", err_addr, 0);
    @(negedge clk); resetn = 1'b1;

    dly[1] = 3;
    xfer(32'h0400_0010, 4'h0, 32'h0, 4'b0010, 5, 4, 32'h1234_5678, 1'b0, 1'b0);
    xfer(32'h0300_0000, 4'hF, 32'h1, 4'b0001, 2, 1, 32'hA0A0_0000, 1'b0, 1'b0);
    xfer(32'h0900_0000, 4'h0, 32'h0, 4'b0000, 1, 0, ERR_RD, 1'b1, 1'b1);
    clear_err();

    dly[2] = -1;
    xfer(32'h0500_0000, 4'h0, 32'h0, 4'b0100, 17, 16, ERR_RD, 1'b1, 1'b1);
    dly[2] = 15;
    xfer(32'h0500_0008, 4'h0, 32'h0, 4'b0100, 17, 16, 32'hCAFE_0002, 1'b1, 1'b0);
    clear_err();

    // Master abandons a request mid-wait: no ack, no error.
    dly[3] = -1;
    r0 = resp_cnt;
    @(posedge clk); #1 m_valid = 1'b1; m_addr = 32'h0600_0000;
    repeat (4) @(negedge clk);
    chk("abort_s_valid", s_valid, 4'b1000);
    @(posedge clk); #1 m_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_s_valid_drop", s_valid, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_ready", resp_cnt - r0, 0);
    chk("abort_no_err", err_flag, 0);

    // Clear pulse landing on the error cycle loses to the set.
    exp_q.push_back(ERR_RD);
    @(posedge clk); #1 m_valid = 1'b1; m_addr = 32'h0A00_0000;
    @(negedge clk); @(negedge clk);
    chk("miss_ready", m_ready, 1);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    chk("set_wins", err_flag, 1);
    chk("err_addr_set_wins", err_addr, 32'h0A00_0000);

    // Asynchronous reset while waiting on a hung slot.
    dly[2] = -1;
    @(posedge clk); #1 m_valid = 1'b1; m_addr = 32'h0500_0000;
    repeat (3) @(negedge clk);
    chk("pre_rst_s_valid", s_valid, 4'b0100);
    resetn = 1'b0;
    #1;
    chk("arst_s_valid", s_valid, 0);
    chk("arst_m_ready", m_ready, 0);
    chk("arst_m_rdata", m_rdata, 0);
    chk("arst_err_flag", err_flag, 0);
    chk("arst_err_addr", err_addr, 0);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    xfer(32'h0300_0004, 4'h0, 32'h0, 4'b0001, 2, 1, 32'hA0A0_0000, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
